// File: rtl/axi_req_arbiter_ldmx.sv
// axi_req_arbiter_ldmx: two-requester round-robin arbiter onto one shared register-bus port.
// Optional WAIT timeout is enabled by defining AXI_ARB_TIMEOUT_EN.
`default_nettype none

module axi_req_arbiter_ldmx #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        axilClk,
  input  logic        axilRstN,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [59:0] req_addr,
  output logic [1:0]  req_ack,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [29:0] raddr,
  output logic [29:0] waddr,
  output logic        rstart,
  output logic        wstart,
  output logic        rready,
  output logic        bready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic [1:0]  bresp,
  input  logic        rvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic [7:0]  late_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q;
  logic        gnt_q;
  logic        last_q;
  logic        wr_q;
  logic [1:0]  req_ack_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic [29:0] raddr_q;
  logic [29:0] waddr_q;
  logic        rstart_q;
  logic        wstart_q;
  logic [7:0]  late_q;
  logic [7:0]  late_d;

  logic        gnt_d;
  logic [29:0] addr_sel;
  logic        rd_match;
  logic        wr_match;
  logic        to_hit;
  logic        wait_done;
  logic [31:0] done_data;
  logic        done_err;
  logic [1:0]  late_inc;
  logic [8:0]  late_sum;

`ifdef AXI_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  assign to_hit = (to_cnt_q + 16'd1) == 16'(TIMEOUT_CYC);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYC);
  assign to_hit = 1'b0;
`endif

  // Write completion is signalled by bvalid alone.
  logic unused_wready;
  assign unused_wready = wready;

  always_comb begin
    gnt_d     = (req_valid == 2'b11) ? ~last_q : ~req_valid[0];
    addr_sel  = gnt_d ? req_addr[59:30] : req_addr[29:0];
    rd_match  = (state_q == WAIT) && !wr_q && rvalid;
    wr_match  = (state_q == WAIT) && wr_q && bvalid;
    wait_done = rd_match || wr_match || ((state_q == WAIT) && to_hit);
    done_data = 32'hDEAD_BEEF;
    done_err  = 1'b1;
    if (rd_match) begin
      done_data = rdata;
      done_err  = |rresp;
    end else if (wr_match) begin
      done_data = '0;
      done_err  = |bresp;
    end
    // Every response beat not consumed as the awaited completion is late.
    late_inc = {1'b0, rvalid && !rd_match} + {1'b0, bvalid && !wr_match};
    late_sum = {1'b0, late_q} + {7'b0, late_inc};
    late_d   = late_sum[8] ? 8'hFF : late_sum[7:0];
  end

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      wr_q        <= 1'b0;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      rstart_q    <= 1'b0;
      wstart_q    <= 1'b0;
      late_q      <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      late_q    <= late_d;
      req_ack_q <= '0;
      rstart_q  <= 1'b0;
      wstart_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            gnt_q     <= gnt_d;
            last_q    <= gnt_d;
            wr_q      <= req_write[gnt_d];
            req_ack_q <= gnt_d ? 2'b10 : 2'b01;
            if (req_write[gnt_d]) begin
              wstart_q <= 1'b1;
              waddr_q  <= addr_sel;
            end else begin
              rstart_q <= 1'b1;
              raddr_q  <= addr_sel;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef AXI_ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        WAIT: begin
          if (wait_done) begin
            state_q     <= RESP;
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            rsp_data_q  <= done_data;
            rsp_err_q   <= done_err;
            raddr_q     <= '0;
            waddr_q     <= '0;
          end
`ifdef AXI_ARB_TIMEOUT_EN
          else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign rstart    = rstart_q;
  assign wstart    = wstart_q;
  assign rready    = 1'b1;
  assign bready    = 1'b1;
  assign late_cnt  = late_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_req_arbiter_ldmx.sv
// Directed, table-driven bench for axi_req_arbiter_ldmx.
`default_nettype none

module tb_axi_req_arbiter_ldmx;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic        axilClk = 1'b0;
  logic        axilRstN = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [59:0] req_addr = '0;
  logic [1:0]  req_ack;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [29:0] raddr;
  logic [29:0] waddr;
  logic        rstart;
  logic        wstart;
  logic        rready;
  logic        bready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic [1:0]  bresp = '0;
  logic        rvalid = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [7:0]  late_cnt;

  axi_req_arbiter_ldmx #(.TIMEOUT_CYC(TO_CYC)) dut (
    .axilClk  (axilClk),
    .axilRstN (axilRstN),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_ack  (req_ack),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .raddr    (raddr),
    .waddr    (waddr),
    .rstart   (rstart),
    .wstart   (wstart),
    .rready   (rready),
    .bready   (bready),
    .rdata    (rdata),
    .rresp    (rresp),
    .bresp    (bresp),
    .rvalid   (rvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .late_cnt (late_cnt)
  );

  always #5 axilClk = ~axilClk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  wr;
    logic [29:0] a0;
    logic [29:0] a1;
    int          dly;
    bit          stray;
    logic [31:0] dat;
    logic [1:0]  resp;
    int          g;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_late;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge axilClk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic        wr;
    logic [29:0] a;
    wr = v.wr[v.g];
    a  = (v.g == 1) ? v.a1 : v.a0;
    req_valid = v.rv;
    req_write = v.wr;
    req_addr  = {v.a1, v.a0};
    tick;
    chk("issue_ack", {30'd0, req_ack}, (v.g == 1) ? 32'd2 : 32'd1);
    chk("issue_start", {30'd0, rstart, wstart}, wr ? 32'd1 : 32'd2);
    chk("issue_addr", {2'b0, (wr ? waddr : raddr)}, {2'b0, a});
    req_valid = '0;
    tick;
    chk("wait_ack", {30'd0, req_ack}, 32'd0);
    for (int i = 0; i < v.dly; i++) begin
      if (v.stray && i == 0) begin
        if (wr) rvalid = 1'b1;
        else begin
          bvalid = 1'b1;
          bresp  = 2'b11;
        end
      end
      tick;
      rvalid = 1'b0;
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk("wait_norsp", {30'd0, rsp_valid}, 32'd0);
    end
    chk("wait_addr", {2'b0, (wr ? waddr : raddr)}, {2'b0, a});
    rdata = v.dat;
    if (wr) begin
      bvalid = 1'b1;
      bresp  = v.resp;
    end else begin
      rvalid = 1'b1;
      rresp  = v.resp;
    end
    tick;
    rvalid = 1'b0;
    bvalid = 1'b0;
    rresp  = '0;
    bresp  = '0;
    rdata  = '0;
    chk("rsp_valid", {30'd0, rsp_valid}, (v.g == 1) ? 32'd2 : 32'd1);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("late_cnt", {24'd0, late_cnt}, {24'd0, v.exp_late});
    rsp_ready = (v.g == 1) ? 2'b10 : 2'b01;
    tick;
    rsp_ready = '0;
    chk("idle_rsp", {30'd0, rsp_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, {30'd0, req_ack}, 32'd0);
    chk({tag, "_rspv"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_start"}, {30'd0, rstart, wstart}, 32'd0);
    chk({tag, "_raddr"}, {2'b0, raddr}, 32'd0);
    chk({tag, "_waddr"}, {2'b0, waddr}, 32'd0);
    chk({tag, "_ready"}, {30'd0, rready, bready}, 32'd3);
    chk({tag, "_data"}, rsp_data, 32'd0);
    chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_late"}, {24'd0, late_cnt}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          rv     wr     a0              a1              dly str dat            rsp  g  exp_data       err  late
    tbl[0] = '{2'b01, 2'b00, 30'h0010_0004, 30'h0000_0000, 2, 0, 32'h1234_5678, 2'd0, 0, 32'h1234_5678, 1'b0, 8'd0};
    tbl[1] = '{2'b10, 2'b10, 30'h0000_0000, 30'h0001_0000, 0, 0, 32'hFFFF_FFFF, 2'd3, 1, 32'h0000_0000, 1'b1, 8'd0};
    tbl[2] = '{2'b11, 2'b00, 30'h0000_0100, 30'h0000_0200, 1, 1, 32'hA5A5_0001, 2'd0, 0, 32'hA5A5_0001, 1'b0, 8'd1};
    tbl[3] = '{2'b11, 2'b11, 30'h0000_0300, 30'h0000_0400, 1, 1, 32'h0000_0000, 2'd0, 1, 32'h0000_0000, 1'b0, 8'd2};
    tbl[4] = '{2'b11, 2'b01, 30'h1234_5678, 30'h2000_0000, 0, 0, 32'h7777_7777, 2'd1, 0, 32'h0000_0000, 1'b1, 8'd2};
    tbl[5] = '{2'b10, 2'b00, 30'h0000_0000, 30'h3FFF_FFFC, 3, 0, 32'hFFFF_0000, 2'd2, 1, 32'hFFFF_0000, 1'b1, 8'd2};
    tbl[6] = '{2'b01, 2'b00, 30'h0000_0008, 30'h0000_0000, 0, 0, 32'h0000_0000, 2'd0, 0, 32'h0000_0000, 1'b0, 8'd2};

    repeat (3) @(posedge axilClk);
    #1;
    chk_reset_outputs("rst0");
    axilRstN = 1'b1;
    tick;

    foreach (tbl[k]) run_vec(tbl[k]);

    // Response held for 10 cycles while the other requester is pending.
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr  = {30'h0, 30'h3FFF_FFFF};
    tick;
    chk("hold_ack", {30'd0, req_ack}, 32'd1);
    chk("hold_raddr", {2'b0, raddr}, 32'h3FFF_FFFF);
    req_valid = 2'b10;
    req_write = 2'b10;
    tick;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_F00D;
    tick;
    rvalid    = 1'b0;
    rdata     = '0;
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      chk("hold_rspv", {30'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, 32'hCAFE_F00D);
      chk("hold_start", {30'd0, rstart, wstart}, 32'd0);
      tick;
    end
    rsp_ready = 2'b01;
    req_valid = '0;
    tick;
    rsp_ready = '0;
    chk("hold_done", {30'd0, rsp_valid}, 32'd0);

    // Stray responses in IDLE: both in one cycle, then saturation.
    rvalid = 1'b1;
    bvalid = 1'b1;
    tick;
    rvalid = 1'b0;
    bvalid = 1'b0;
    chk("late_dual", {24'd0, late_cnt}, 32'd4);
    rvalid = 1'b1;
    bvalid = 1'b1;
    repeat (130) tick;
    rvalid = 1'b0;
    bvalid = 1'b0;
    tick;
    chk("late_sat", {24'd0, late_cnt}, 32'd255);

    // Reset asserted while waiting for a read response.
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr  = {30'h0, 30'h0000_0155};
    tick;
    req_valid = '0;
    tick;
    chk("pre_rst_raddr", {2'b0, raddr}, 32'h155);
    axilRstN = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    repeat (2) @(posedge axilClk);
    #1;
    axilRstN = 1'b1;

    // Continuous contention after reset: first tie goes to requester 0.
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {30'h0000_0222, 30'h0000_0111};
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_ack", {30'd0, req_ack}, (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("rr_raddr", {2'b0, raddr}, (i % 2 == 1) ? 32'h222 : 32'h111);
      tick;
      chk("rr_ack_pulse", {30'd0, req_ack}, 32'd0);
      rvalid = 1'b1;
      rdata  = 32'(i + 16);
      tick;
      rvalid = 1'b0;
      chk("rr_rspv", {30'd0, rsp_valid}, (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("rr_data", rsp_data, 32'(i + 16));
      if (i == 3) req_valid = '0;
      tick;
      chk("rr_idle", {30'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = '0;
    rdata     = '0;

`ifdef AXI_ARB_TIMEOUT_EN
    // Read with no rvalid times out after 8 WAIT cycles; the late rvalid is counted.
    req_valid = 2'b01;
    tick;
    req_valid = '0;
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", {30'd0, rsp_valid}, 32'd0);
      tick;
    end
    chk("to_rspv", {30'd0, rsp_valid}, 32'd1);
    chk("to_data", rsp_data, 32'hDEAD_BEEF);
    chk("to_err", {31'd0, rsp_err}, 32'd1);
    rvalid = 1'b1;
    rdata  = 32'h1111_1111;
    tick;
    rvalid = 1'b0;
    chk("to_late", {24'd0, late_cnt}, 32'd1);
    chk("to_data_kept", rsp_data, 32'hDEAD_BEEF);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = '0;
    chk("to_idle", {30'd0, rsp_valid}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
